pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/adder_pkg.sv | 15 +
 rtl/seg_adder.sv | 34 +++
 rtl/pipe_adder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   op_e      : operation encoding carried on in_op (ADD = 0, SUB = 1)
//   ADDER_N   : default operand/result width
//   ADDER_SEG : default bits added per pipeline stage
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned ADDER_N   = 12;
  localparam int unsigned ADDER_SEG = 4;

endpackage

// File: rtl/seg_adder.sv
// One pipeline segment: W-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a_i, b_i : W-bit operand slices
//   ci_i     : carry into bit 0 of the slice
//   sum_o    : W-bit sum slice
//   co_o     : carry out of the slice MSB
//   cmsb_o   : carry into the slice MSB (used for signed overflow)
module seg_adder #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] sum_o,
  output logic         co_o,
  output logic         cmsb_o
);

  logic [W:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = ci_i;
    for (int unsigned i = 0; i < W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o   = c[W];
  assign cmsb_o = c[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor, SEG bits per stage, S = N/SEG
// stages, valid/ready on both sides. SUB is A + ~B + 1.
// Optional macro PIPE_ADDER_SAT_EN: clamp the result on signed overflow.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_a, in_b, in_op   : operands and operation (0 = ADD, 1 = SUB)
//   out_valid/out_ready : output handshake
//   out_sum             : N-bit result
//   out_cout            : carry out of bit N-1 (SUB: 1 = no borrow)
//   out_ovf             : signed overflow
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned N   = ADDER_N,
  parameter int unsigned SEG = ADDER_SEG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int unsigned S = N / SEG;

  // Stage registers; a_q/b_q of the last stage are never needed.
  logic [S-1:0] v_q;
  logic [S-1:0] c_q;
  logic [N-1:0] a_q   [S];
  logic [N-1:0] b_q   [S];
  logic [N-1:0] sum_q [S];
  logic         ovf_q;

  // Per-stage inputs (from the port for stage 0, from stage k-1 otherwise)
  logic [S-1:0] en;
  logic [S-1:0] v_src;
  logic [S-1:0] c_src;
  logic [N-1:0] a_src [S];
  logic [N-1:0] b_src [S];
  logic [N-1:0] s_src [S];
  logic [N-1:0] sum_d [S];
  logic         ovf_d;

  logic [S*SEG-1:0] seg_a;
  logic [S*SEG-1:0] seg_b;
  logic [S*SEG-1:0] seg_s;
  logic [S-1:0]     seg_co;
  logic             seg_cm [S];

  op_e op;
  assign op = op_e'(in_op);

  assign in_ready = !(v_q[S-1] && !out_ready);

  // A stage may load when it is empty or its contents move on, so bubbles
  // collapse under a stall while valid results hold in place.
  always_comb begin
    en      = '0;
    en[S-1] = !v_q[S-1] || out_ready;
    for (int unsigned k = S - 1; k > 0; k--) begin
      en[k-1] = !v_q[k-1] || en[k];
    end
  end

  always_comb begin
    a_src    = '{default: '0};
    b_src    = '{default: '0};
    s_src    = '{default: '0};
    v_src    = '0;
    c_src    = '0;
    seg_a    = '0;
    seg_b    = '0;
    a_src[0] = in_a;
    b_src[0] = (op == OP_SUB) ? ~in_b : in_b;
    c_src[0] = (op == OP_SUB);
    v_src[0] = in_valid && in_ready;
    for (int unsigned k = 1; k < S; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = sum_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end
    for (int unsigned k = 0; k < S; k++) begin
      seg_a[k*SEG +: SEG] = a_src[k][k*SEG +: SEG];
      seg_b[k*SEG +: SEG] = b_src[k][k*SEG +: SEG];
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_seg
    seg_adder #(.W(SEG)) u_seg (
      .a_i    (seg_a[k*SEG +: SEG]),
      .b_i    (seg_b[k*SEG +: SEG]),
      .ci_i   (c_src[k]),
      .sum_o  (seg_s[k*SEG +: SEG]),
      .co_o   (seg_co[k]),
      .cmsb_o (seg_cm[k])
    );
  end

  always_comb begin
    sum_d = '{default: '0};
    for (int unsigned k = 0; k < S; k++) begin
      sum_d[k]               = s_src[k];
      sum_d[k][k*SEG +: SEG] = seg_s[k*SEG +: SEG];
    end
    ovf_d = seg_co[S-1] ^ seg_cm[S-1];
`ifdef PIPE_ADDER_SAT_EN
    if (ovf_d) begin
      sum_d[S-1] = a_src[S-1][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < S; k++) begin
        sum_q[k] <= '0;
        if (k < S - 1) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end
    end else begin
      for (int unsigned k = 0; k < S; k++) begin
        if (en[k]) begin
          v_q[k]   <= v_src[k];
          c_q[k]   <= seg_co[k];
          sum_q[k] <= sum_d[k];
          if (k < S - 1) begin
            a_q[k] <= a_src[k];
            b_q[k] <= b_src[k];
          end
        end
      end
      if (en[S-1]) ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[S-1];
  assign out_sum   = sum_q[S-1];
  assign out_cout  = c_q[S-1];
  assign out_ovf   = ovf_q;

endmodule
